// File: rtl/fetch_unit.sv
// Instruction fetch unit. It issues at most one word-aligned memory request at
// a time, waits for the response, and holds the returned instruction in a
// one-entry buffer until decode takes it. A redirect from execute squashes any
// in-flight response. The fetch then restarts at the redirect target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  // IDLE: free to request. WAIT: response pending and wanted.
  // DROP: response pending but stale, so it is discarded on arrival.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic        buf_free;
  logic        req_fire;

  // Request handshake: only ask for a new word when the buffer can take it.
  always_comb begin
    buf_free       = !id_valid_q || id_ready;
    imem_req_addr  = pc_q & ALIGN_MASK;
    imem_req_valid = !rst && (state_q == IDLE) && !redirect_valid && buf_free;
    req_fire       = imem_req_valid && imem_req_ready;
  end

  // Next-state logic for the FSM, the PCs and the decode buffer.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;

    // Decode consumed the buffered word; a load below may refill it.
    if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          req_pc_d = imem_req_addr;
          pc_d     = imem_req_addr + 32'd4;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (!redirect_valid) begin
            id_instr_d = imem_rsp_data;
            id_pc_d    = req_pc_q;
            id_valid_d = 1'b1;
          end
          state_d = IDLE;
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect wins over everything: new PC, buffered word squashed.
    if (redirect_valid) begin
      pc_d       = redirect_pc & ALIGN_MASK;
      id_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0;
      id_pc_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // Decode-side outputs come straight from the buffer.
  always_comb begin
    id_valid = id_valid_q;
    id_instr = id_instr_q;
    id_pc    = id_pc_q;
  end

endmodule
